serial_addsub: RTL and testbench
================================

# serial_addsub

Parametrised multi-cycle two's-complement adder/subtractor. It processes `DIGIT` bits per clock, LSB digit first, using a single `DIGIT`-bit carry-chain slice and a registered carry. It is the area-reduced, flag-complete successor to the combinational 8-bit add/sub slice. It sits behind a simple start/done handshake in the datapath and reports carry, signed overflow for both modes, zero and negative.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits. Must be ≥ 2.
- `DIGIT`, default 1: bits processed per cycle. `WIDTH % DIGIT == 0` is required; `N = WIDTH/DIGIT` digit cycles.

Ports:
- `clk`  in  1: single clock. All state changes on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request. Sampled only while idle (`busy`=0).
- `Data0`  in  `WIDTH`: operand A. Sampled on the accepted `start` edge only.
- `Data1`  in  `WIDTH`: operand B. Sampled on the accepted `start` edge only.
- `mode`  in  1: 1 = addition (A+B), 0 = subtraction (A−B). Sampled with the operands.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle completion pulse.
- `result`  out  `WIDTH`: sum or difference.
- `carry_out`  out  1: carry out of the MSB. On subtraction, 1 = no borrow.
- `overflow`  out  1: signed overflow, valid in both modes.
- `zero`  out  1: `result` == 0.
- `negative`  out  1: `result[WIDTH-1]`.

## Operation
- Subtraction is computed as A + ~B + 1. The initial carry is `~mode`, and B is inverted per digit when `mode`=0.
- States:
  - IDLE: `busy`=0. On `start`=1, latch A, B and mode into internal shift registers, load carry = `~mode`, clear the digit counter, and go to RUN.
  - RUN: `busy`=1. Each cycle:
    - add the low `DIGIT` bits of A, B' and the carry;
    - shift the sum digit into the MSB end of an internal accumulator;
    - shift A and B' right by `DIGIT`;
    - register the new carry;
    - increment the counter.
  - After the digit with counter = N−1, go to IDLE. On that same edge:
    - load `result` from the completed accumulator;
    - set `carry_out` = final carry;
    - set `overflow` = carry into bit `WIDTH-1` XOR carry out of bit `WIDTH-1`. When `DIGIT`>1, the carry into the MSB is taken from inside the last digit slice.
    - set `zero` and `negative` from the new result;
    - set `done`=1 for exactly one cycle.
- Visible outputs `result`, `carry_out`, `overflow`, `zero` and `negative` change only on a completion edge or on reset. Between those edges they hold the last completed operation's values.
- `start` while `busy`=1 is ignored. It does not queue and does not alter operands.
- `start`=1 in the cycle where `done`=1 is accepted, because the block is already idle. This gives back-to-back operation with one cycle per op of handshake overhead.
- `Data0`, `Data1` and `mode` may change freely after the accepted edge.

## Timing
- Reset (`rst`=1 at an edge) has priority over everything, including a simultaneous `start`. After that edge:
  - state = IDLE;
  - `busy`, `done`, `result`, `carry_out`, `overflow`, `zero`, `negative` = 0. `zero` resets to 0 because no result is valid yet.
- Reset mid-RUN aborts the operation. `done` is not produced, and the outputs take their reset values.
- Latency: `start` accepted at edge k. `busy`=1 after edges k … k+N−1. At edge k+N: `busy`=0, `done`=1, outputs valid. At edge k+N+1: `done`=0.
- Throughput: one operation per N+1 cycles when `start` is held high continuously. Each accepted `start` gives a `done` exactly N edges later.
- `done` and `busy` are never both 1.
- Wrap-around: the result is always mod 2^`WIDTH`. Carry and overflow are reported only through flags; there is no saturation.

## Test plan
- WIDTH=8, DIGIT=1, add 100+27: `done` exactly 8 edges after `start`, `result`=127, `carry_out`=0, `overflow`=0, `zero`=0, `negative`=0.
- Add 100+28: `result`=0x80, `overflow`=1, `negative`=1, `carry_out`=0.
- Add 0xFF+0x01: `result`=0x00, `carry_out`=1, `overflow`=0, `zero`=1.
- Subtract 5−7: `result`=0xFE, `carry_out`=0, `overflow`=0, `negative`=1.
- Subtract 0x80−0x01: `result`=0x7F, `carry_out`=1, `overflow`=1.
- Handshake and reset:
  - `start` re-pulsed at cycle 3 of an op with new operands: ignored, and the original result is reported.
  - `rst` at cycle 4 of an op: no `done`, all outputs 0.
  - WIDTH=16, DIGIT=4: 0x7FFF+0x0001 gives `done` after 4 edges, `result`=0x8000, `overflow`=1.
  - Random back-to-back ops against a golden model, with `start` held high: one `done` every 5 cycles.

Source files
------------

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial two's-complement adder/subtractor with start/done handshake
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Data0,
    input  logic [WIDTH-1:0] Data1,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    // Number of digit cycles per operation and the counter that walks them.
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;
    logic             done_q, done_d;

    // Digit slice signals.
    logic [DIGIT-1:0]       a_dig;
    logic [DIGIT-1:0]       b_dig;
    logic [DIGIT:0]         dig_sum;
    logic [DIGIT-1:0]       sum_dig;
    logic                   dig_cout;
    logic                   dig_cmsb;
    logic [WIDTH+DIGIT-1:0] acc_wide;
    logic [WIDTH-1:0]       acc_next;

    // One DIGIT-wide carry-chain slice; B is inverted here for subtraction.
    always_comb begin
        a_dig    = a_q[DIGIT-1:0];
        b_dig    = mode_q ? b_q[DIGIT-1:0] : ~b_q[DIGIT-1:0];
        dig_sum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
        sum_dig  = dig_sum[DIGIT-1:0];
        dig_cout = dig_sum[DIGIT];
        // Carry into the top bit of the slice recovered from its sum bit.
        dig_cmsb = sum_dig[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
        // New sum digit enters at the MSB end; after N digits the LSB digit
        // has travelled down to bit 0.
        acc_wide = {sum_dig, acc_q};
        acc_next = acc_wide[WIDTH+DIGIT-1:DIGIT];
    end

    // Next-state: operand capture in IDLE, one digit per cycle in RUN.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        mode_d      = mode_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        negative_d  = negative_q;
        done_d      = 1'b0;

        if (state_q == S_IDLE) begin
            if (start) begin
                a_d     = Data0;
                b_d     = Data1;
                mode_d  = mode;
                carry_d = ~mode;
                cnt_d   = '0;
                acc_d   = '0;
                state_d = S_RUN;
            end
        end else begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            acc_d   = acc_next;
            carry_d = dig_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_DIGIT) begin
                state_d     = S_IDLE;
                result_d    = acc_next;
                carry_out_d = dig_cout;
                overflow_d  = dig_cmsb ^ dig_cout;
                zero_d      = (acc_next == '0);
                negative_d  = acc_next[WIDTH-1];
                done_d      = 1'b1;
            end
        end
    end

    // State and visible-output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            mode_q      <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            negative_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            mode_q      <= mode_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            negative_q  <= negative_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign negative  = negative_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed and back-to-back checks for serial_addsub
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic        s8_start = 1'b0;
    logic [7:0]  s8_a = '0, s8_b = '0;
    logic        s8_mode = 1'b0;
    logic        s8_busy, s8_done, s8_c, s8_o, s8_z, s8_n;
    logic [7:0]  s8_result;

    logic        s16_start = 1'b0;
    logic [15:0] s16_a = '0, s16_b = '0;
    logic        s16_mode = 1'b0;
    logic        s16_busy, s16_done, s16_c, s16_o, s16_z, s16_n;
    logic [15:0] s16_result;

    int n_pass  = 0;
    int n_total = 0;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .Data0(s8_a), .Data1(s8_b), .mode(s8_mode),
        .busy(s8_busy), .done(s8_done), .result(s8_result), .carry_out(s8_c),
        .overflow(s8_o), .zero(s8_z), .negative(s8_n)
    );

    serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(s16_start), .Data0(s16_a), .Data1(s16_b), .mode(s16_mode),
        .busy(s16_busy), .done(s16_done), .result(s16_result), .carry_out(s16_c),
        .overflow(s16_o), .zero(s16_z), .negative(s16_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Golden 16-bit model: {carry, overflow, zero, negative, result}.
    function automatic logic [19:0] model16(input logic [15:0] a, input logic [15:0] b, input logic m);
        logic [16:0] full;
        logic [15:0] r;
        logic        ov;
        if (m) full = {1'b0, a} + {1'b0, b};
        else   full = {1'b0, a} + {1'b0, ~b} + 17'd1;
        r = full[15:0];
        if (m) ov = (a[15] == b[15]) && (r[15] != a[15]);
        else   ov = (a[15] != b[15]) && (r[15] != a[15]);
        return {full[16], ov, (r == 16'd0), r[15], r};
    endfunction

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic m,
                        input logic [7:0] er, input logic [3:0] ef);
        int lat;
        @(negedge clk);
        s8_a = a; s8_b = b; s8_mode = m; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0; s8_a = ~a; s8_b = ~b; s8_mode = ~m;
        lat = -1;
        for (int i = 0; i <= 20; i++) begin
            if (s8_done) begin lat = i; break; end
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(lat), 32'd8);
        chk({tag, "_result"}, 32'(s8_result), 32'(er));
        chk({tag, "_flags"}, 32'({s8_c, s8_o, s8_z, s8_n}), 32'(ef));
        chk({tag, "_busy_at_done"}, 32'(s8_busy), 32'd0);
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic m,
                         input logic [15:0] er, input logic [3:0] ef);
        int lat;
        @(negedge clk);
        s16_a = a; s16_b = b; s16_mode = m; s16_start = 1'b1;
        @(negedge clk);
        s16_start = 1'b0; s16_a = ~a; s16_b = ~b; s16_mode = ~m;
        lat = -1;
        for (int i = 0; i <= 20; i++) begin
            if (s16_done) begin lat = i; break; end
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_result"}, 32'(s16_result), 32'(er));
        chk({tag, "_flags"}, 32'({s16_c, s16_o, s16_z, s16_n}), 32'(ef));
    endtask

    initial begin
        int          lat;
        logic        saw;
        logic [15:0] qa, qb;
        logic        qm;
        logic [19:0] expv;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_state8", 32'({s8_busy, s8_done, s8_result, s8_c, s8_o, s8_z, s8_n}), 32'd0);
        chk("rst_state16", 32'({s16_busy, s16_done, s16_result, s16_c, s16_o, s16_z, s16_n}), 32'd0);
        rst = 1'b0;

        // Directed 8-bit vectors, flags as {carry, overflow, zero, negative}
        run8("add_100_27",  8'd100, 8'd27,  1'b1, 8'h7F, 4'b0000);
        run8("add_100_28",  8'd100, 8'd28,  1'b1, 8'h80, 4'b0101);
        run8("add_ff_01",   8'hFF,  8'h01,  1'b1, 8'h00, 4'b1010);
        run8("sub_5_7",     8'd5,   8'd7,   1'b0, 8'hFE, 4'b0001);
        run8("sub_80_01",   8'h80,  8'h01,  1'b0, 8'h7F, 4'b1100);

        // start re-pulsed mid-operation with new operands is ignored
        @(negedge clk);
        s8_a = 8'h10; s8_b = 8'h20; s8_mode = 1'b1; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        lat = -1;
        for (int i = 0; i <= 20; i++) begin
            if (s8_done) begin lat = i; break; end
            s8_start = (i == 2);
            if (i == 2) begin s8_a = 8'h01; s8_b = 8'h01; s8_mode = 1'b0; end
            @(negedge clk);
        end
        s8_start = 1'b0;
        chk("repulse_latency", 32'(lat), 32'd8);
        chk("repulse_result", 32'(s8_result), 32'h30);
        chk("repulse_flags", 32'({s8_c, s8_o, s8_z, s8_n}), 32'd0);
        repeat (3) @(negedge clk);
        chk("hold_result", 32'({s8_busy, s8_done, s8_result}), 32'h030);

        // Reset in the middle of an operation aborts it
        @(negedge clk);
        s8_a = 8'h11; s8_b = 8'h22; s8_mode = 1'b1; s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_busy_before", 32'(s8_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_outputs", 32'({s8_busy, s8_done, s8_result, s8_c, s8_o, s8_z, s8_n}), 32'd0);
        saw = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (s8_done) saw = 1'b1;
        end
        chk("rst_mid_no_done", 32'(saw), 32'd0);

        // Reset has priority over a simultaneous start
        rst = 1'b1; s8_start = 1'b1; s8_a = 8'h01;
        @(negedge clk);
        rst = 1'b0; s8_start = 1'b0;
        chk("rst_over_start", 32'(s8_busy), 32'd0);

        // WIDTH=16, DIGIT=4
        run16("w16_add_7fff_1",  16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b0101);
        run16("w16_sub_8000_1",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b1100);
        run16("w16_add_mixed",   16'h1234, 16'h4321, 1'b1, 16'h5555, 4'b0000);
        run16("w16_sub_equal",   16'h1234, 16'h1234, 1'b0, 16'h0000, 4'b1010);

        // Back-to-back with start held high: one done every N+1 = 5 cycles
        @(negedge clk);
        qa = 16'($urandom); qb = 16'($urandom); qm = 1'($urandom);
        s16_a = qa; s16_b = qb; s16_mode = qm; s16_start = 1'b1;
        for (int j = 0; j < 6; j++) begin
            for (int g = 1; g <= 4; g++) begin
                @(negedge clk);
                chk("b2b_gap_done", 32'(s16_done), 32'd0);
                s16_a = 16'($urandom); s16_b = 16'($urandom); s16_mode = 1'($urandom);
            end
            @(negedge clk);
            expv = model16(qa, qb, qm);
            chk("b2b_done", 32'({s16_done, s16_busy}), 32'b10);
            chk("b2b_result", 32'(s16_result), 32'(expv[15:0]));
            chk("b2b_flags", 32'({s16_c, s16_o, s16_z, s16_n}), 32'(expv[19:16]));
            qa = 16'($urandom); qb = 16'($urandom); qm = 1'($urandom);
            s16_a = qa; s16_b = qb; s16_mode = qm;
            if (j == 5) s16_start = 1'b0;
        end
        repeat (8) @(negedge clk);
        chk("b2b_idle_after", 32'({s16_busy, s16_done}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
